uart_cmd_decode: RTL and testbench
==================================

Name: uart_cmd_decode

Overview:
- Byte-level command parser that sits directly downstream of uart_rx in the SDRAM test design.
- Consumes each received byte (rx_data with the one-cycle po_flag strobe) and turns framed host commands into SDRAM control: write-FIFO pushes, a write trigger and a read trigger.
- Handles inter-byte timeout, and rejects commands that arrive while the SDRAM controller is busy.

Parameters:
- BURST_LEN, 4: data bytes per write frame (1..256).
- WR_CMD, 8'h55: header byte that starts a write frame.
- RD_CMD, 8'hAA: single-byte read command.
- TIMEOUT_CYC, 100000: maximum idle clocks between bytes inside a write frame before abort (>=2).

Ports:
- clk  in  1  system clock; the single clock domain for the block.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when po_flag=1.
- po_flag  in  1  one-cycle strobe marking a new rx_data byte.
- sdram_busy  in  1  SDRAM controller is executing a burst.
- wfifo_wr_en  out  1  one-cycle push into the SDRAM write FIFO.
- wfifo_data  out  8  data for wfifo_wr_en.
- wfifo_clr  out  1  one-cycle flush request to the write FIFO (abort).
- wr_trig  out  1  one-cycle pulse: a full burst is in the FIFO; start the SDRAM write.
- rd_trig  out  1  one-cycle pulse: start the SDRAM read burst.
- busy  out  1  a write frame is in progress (state != IDLE).
- frame_err  out  1  one-cycle pulse on a dropped command or a timeout abort.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including wfifo_data=8'h00. Byte and timeout counters are 0.
- Every output is registered. "Cycle N" means the cycle in which po_flag=1 is sampled.
- States and transitions:
  - IDLE:
    - po_flag and rx_data==WR_CMD and !sdram_busy: go to WDATA; clear byte_cnt and to_cnt.
    - po_flag and rx_data==RD_CMD and !sdram_busy: rd_trig=1 at N+1; stay in IDLE.
    - po_flag and (WR_CMD or RD_CMD) while sdram_busy=1: command dropped; frame_err=1 at N+1; stay in IDLE.
    - po_flag with any other byte: ignored silently.
  - WDATA:
    - Each po_flag: wfifo_wr_en=1 and wfifo_data=rx_data at N+1; byte_cnt increments; to_cnt is cleared.
    - Byte values are not interpreted in this state; 0x55 and 0xAA are plain data here.
    - sdram_busy is ignored here; the FIFO buffers the data.
    - When the byte accepted is number BURST_LEN (byte_cnt==BURST_LEN-1): go to WTRIG.
    - A cycle with no po_flag increments to_cnt.
    - When to_cnt==TIMEOUT_CYC-1 with no po_flag: abort. wfifo_clr=1 and frame_err=1 for one cycle in the next cycle; go to IDLE.
  - WTRIG: wr_trig=1 for exactly one cycle at N+2 relative to the last data byte. This places it one cycle after the final wfifo_wr_en. Return to IDLE.
- Simultaneous events:
  - po_flag in the same cycle as the timeout terminal count: the byte wins. It is accepted, to_cnt clears and there is no abort.
  - po_flag while in WTRIG: the byte is evaluated with the IDLE rules, so a back-to-back command one cycle after the last data byte is not lost.
- po_flag high for k consecutive cycles is treated as k bytes. The upstream contract is a single-cycle strobe.
- Widths:
  - byte_cnt is $clog2(BURST_LEN+1) bits.
  - to_cnt is $clog2(TIMEOUT_CYC) bits.
  - Neither counter wraps: byte_cnt stops at the terminal value and to_cnt stops at abort.
- Reset mid-frame: immediate return to IDLE, all outputs 0, no wfifo_clr. The FIFO's own reset covers it.
- Pulse outputs are never asserted for more than one consecutive cycle per event.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - state enum (IDLE, WDATA, WTRIG);
  - default command codes CMD_WR=8'h55 and CMD_RD=8'hAA;
  - the 9600-baud byte-time constant used to derive TIMEOUT_CYC at the top level.
- No sub-module is needed: the FSM and two counters sit in one file.
- Integration in the SDRAM top: uart_rx feeds uart_cmd_decode, which feeds the wfifo and the SDRAM controller.

Test Plan:
- BURST_LEN=4: send 55,11,22,33,44 with 20-cycle gaps -> four wfifo_wr_en pulses with data 11,22,33,44, each at N+1; wr_trig one cycle at N+2 of byte 44; busy falls with the wr_trig cycle; frame_err never asserted.
- Send AA with sdram_busy=0 -> rd_trig=1 for exactly the one cycle N+1; no wfifo activity. Repeat with sdram_busy=1 -> no rd_trig; frame_err at N+1.
- TIMEOUT_CYC=100: send 55,11,22 then silence -> wfifo_clr and frame_err together 100 cycles after the 22 strobe, one cycle wide; state IDLE. A following AA produces rd_trig.
- Send 00,7F,44 in IDLE -> no output activity. Send 55,AA,55,AA,01 -> data AA,55,AA,01 written and wr_trig; no rd_trig.
- Send 55 then byte 11 exactly on the timeout terminal cycle -> byte accepted, no abort. Then send 55 one cycle after wr_trig -> new frame starts and busy=1.
- Assert rst for 1 cycle after 55,11 -> all outputs 0 the next cycle, no wfifo_clr. A subsequent full frame completes normally.

Source files
------------

// File: rtl/uart_cmd_decode_pkg.sv
// Shared types and constants for the UART command decoder.
// Holds the FSM state encoding, the default command bytes, and the
// byte-time figure the SDRAM top uses to size the inter-byte timeout.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      WTRIG = 2'd2
   } state_t;

   localparam logic [7:0] CMD_WR = 8'h55;
   localparam logic [7:0] CMD_RD = 8'hAA;

   // One 10-bit UART character at 9600 baud on a 50 MHz system clock.
   localparam int SYS_CLK_HZ    = 50_000_000;
   localparam int UART_BAUD     = 9600;
   localparam int BYTE_CYC_9600 = (SYS_CLK_HZ / UART_BAUD) * 10;

   // Clock cycles spanned by n_bytes back-to-back UART characters.
   function automatic int byte_gap_cycles(input int clk_hz, input int baud, input int n_bytes);
      return (clk_hz / baud) * 10 * n_bytes;
   endfunction

endpackage

// File: rtl/uart_cmd_decode_if.sv
// Byte-in / SDRAM-control-out bundle between uart_rx, the command
// decoder, the write FIFO and the SDRAM controller.
// master drives received bytes and the busy flag; slave is the decoder.
interface uart_cmd_if;

   logic [7:0] rx_data;
   logic       po_flag;
   logic       sdram_busy;
   logic       wfifo_wr_en;
   logic [7:0] wfifo_data;
   logic       wfifo_clr;
   logic       wr_trig;
   logic       rd_trig;
   logic       busy;
   logic       frame_err;

   modport master (
      output rx_data, po_flag, sdram_busy,
      input  wfifo_wr_en, wfifo_data, wfifo_clr, wr_trig, rd_trig, busy, frame_err
   );

   modport slave (
      input  rx_data, po_flag, sdram_busy,
      output wfifo_wr_en, wfifo_data, wfifo_clr, wr_trig, rd_trig, busy, frame_err
   );

endinterface

// File: rtl/uart_cmd_decode.sv
// Byte-level host command parser sitting behind uart_rx.
// A WR_CMD header opens a frame of BURST_LEN data bytes that are pushed
// into the SDRAM write FIFO, followed by a one-cycle write trigger.
// RD_CMD fires a read trigger. Commands arriving while the SDRAM
// controller is busy are dropped and flagged; a stalled frame is
// aborted after TIMEOUT_CYC idle clocks and the FIFO is flushed.
module uart_cmd_decode
   import uart_cmd_pkg::*;
#(
   parameter int         BURST_LEN   = 4,
   parameter logic [7:0] WR_CMD      = CMD_WR,
   parameter logic [7:0] RD_CMD      = CMD_RD,
   // About two character times at 9600 baud (see BYTE_CYC_9600).
   parameter int         TIMEOUT_CYC = 100000
)(
   input  logic       clk,
   input  logic       rst,
   uart_cmd_if.slave  bus
);

   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);

   localparam logic [BW-1:0] LAST_BYTE = BW'(BURST_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

   state_t          state_reg;
   logic [BW-1:0]   byte_cnt_reg;
   logic [TW-1:0]   to_cnt_reg;

   logic            wfifo_wr_en_reg;
   logic [7:0]      wfifo_data_reg;
   logic            wfifo_clr_reg;
   logic            wr_trig_reg;
   logic            rd_trig_reg;
   logic            busy_reg;
   logic            frame_err_reg;

   logic            is_wr_cmd;
   logic            is_rd_cmd;

   assign is_wr_cmd = (bus.rx_data == WR_CMD);
   assign is_rd_cmd = (bus.rx_data == RD_CMD);

   assign bus.wfifo_wr_en = wfifo_wr_en_reg;
   assign bus.wfifo_data  = wfifo_data_reg;
   assign bus.wfifo_clr   = wfifo_clr_reg;
   assign bus.wr_trig     = wr_trig_reg;
   assign bus.rd_trig     = rd_trig_reg;
   assign bus.busy        = busy_reg;
   assign bus.frame_err   = frame_err_reg;

   // Command FSM with its byte and timeout counters; every output is a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         byte_cnt_reg    <= '0;
         to_cnt_reg      <= '0;
         wfifo_wr_en_reg <= 1'b0;
         wfifo_data_reg  <= 8'h00;
         wfifo_clr_reg   <= 1'b0;
         wr_trig_reg     <= 1'b0;
         rd_trig_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         frame_err_reg   <= 1'b0;
      end else begin
         // Pulse outputs default low so each event yields a single cycle.
         wfifo_wr_en_reg <= 1'b0;
         wfifo_clr_reg   <= 1'b0;
         wr_trig_reg     <= 1'b0;
         rd_trig_reg     <= 1'b0;
         frame_err_reg   <= 1'b0;

         case (state_reg)
            // WTRIG shares the IDLE byte rules so a command landing right
            // after the last data byte is still honoured.
            IDLE, WTRIG: begin
               if (state_reg == WTRIG) begin
                  wr_trig_reg <= 1'b1;
               end
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               if (bus.po_flag && (is_wr_cmd || is_rd_cmd)) begin
                  if (bus.sdram_busy) begin
                     frame_err_reg <= 1'b1;
                  end else if (is_wr_cmd) begin
                     state_reg    <= WDATA;
                     busy_reg     <= 1'b1;
                     byte_cnt_reg <= '0;
                     to_cnt_reg   <= '0;
                  end else begin
                     rd_trig_reg <= 1'b1;
                  end
               end
            end

            // Payload bytes are pushed verbatim; command codes carry no
            // meaning here and sdram_busy is left to the FIFO to absorb.
            WDATA: begin
               if (bus.po_flag) begin
                  wfifo_wr_en_reg <= 1'b1;
                  wfifo_data_reg  <= bus.rx_data;
                  byte_cnt_reg    <= byte_cnt_reg + BW'(1);
                  to_cnt_reg      <= '0;
                  if (byte_cnt_reg == LAST_BYTE) begin
                     state_reg <= WTRIG;
                  end
               end else if (to_cnt_reg == TO_LAST) begin
                  wfifo_clr_reg <= 1'b1;
                  frame_err_reg <= 1'b1;
                  state_reg     <= IDLE;
                  busy_reg      <= 1'b0;
               end else begin
                  to_cnt_reg <= to_cnt_reg + TW'(1);
               end
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Directed bench for uart_cmd_decode with BURST_LEN=4 and TIMEOUT_CYC=100.
// Responses are sampled 1 ns after the clock edge that captured a strobe,
// so a result due at N+1 is visible as soon as the strobe task returns.
module tb_uart_cmd_decode;

   localparam int BURST_LEN   = 4;
   localparam int TIMEOUT_CYC = 100;

   logic clk;
   logic rst;

   uart_cmd_if bus();

   uart_cmd_decode #(
      .BURST_LEN   (BURST_LEN),
      .WR_CMD      (8'h55),
      .RD_CMD      (8'hAA),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Running pulse tallies sampled mid-cycle; tests compare deltas.
   int n_wr = 0, n_clr = 0, n_wt = 0, n_rt = 0, n_err = 0, n_double = 0;
   logic [4:0] prev_pulses = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [4:0] p;
      p = {bus.wfifo_wr_en, bus.wfifo_clr, bus.wr_trig, bus.rd_trig, bus.frame_err};
      if (p[4]) n_wr++;
      if (p[3]) n_clr++;
      if (p[2]) n_wt++;
      if (p[1]) n_rt++;
      if (p[0]) n_err++;
      if (|(p & prev_pulses)) n_double++;
      prev_pulses = p;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data = b;
      bus.po_flag = 1'b1;
      @(posedge clk);
      #1;
      bus.po_flag = 1'b0;
      $display("t=%0t byte %02h busy_in=%0b -> wr_en=%0b data=%02h clr=%0b wt=%0b rt=%0b busy=%0b err=%0b",
               $time, b, bus.sdram_busy, bus.wfifo_wr_en, bus.wfifo_data, bus.wfifo_clr,
               bus.wr_trig, bus.rd_trig, bus.busy, bus.frame_err);
   endtask

   function automatic logic [5:0] flags();
      return {bus.wfifo_wr_en, bus.wfifo_clr, bus.wr_trig, bus.rd_trig, bus.busy, bus.frame_err};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.rx_data = 8'h00;
      bus.po_flag = 1'b0;
      bus.sdram_busy = 1'b0;
      step(3);
      checks++;
      if (flags() !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b, need 000000", flags());
      end
      checks++;
      if (bus.wfifo_data !== 8'h00) begin
         errors++; $display("FAIL reset_data: got %02h, need 00", bus.wfifo_data);
      end
      @(negedge clk);
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_write_frame();
      logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int e0;
      e0 = n_err;
      strobe(8'h55);
      checks++;
      if (bus.busy !== 1'b1 || bus.wfifo_wr_en !== 1'b0) begin
         errors++; $display("FAIL wr_header: busy=%0b wr_en=%0b, need busy=1 wr_en=0", bus.busy, bus.wfifo_wr_en);
      end
      for (int i = 0; i < 4; i++) begin
         step(19);
         strobe(d[i]);
         checks++;
         if (bus.wfifo_wr_en !== 1'b1 || bus.wfifo_data !== d[i]) begin
            errors++; $display("FAIL wr_data%0d: wr_en=%0b data=%02h, need 1 %02h", i, bus.wfifo_wr_en, bus.wfifo_data, d[i]);
         end
      end
      checks++;
      if (bus.wr_trig !== 1'b0 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL wr_trig_early: wr_trig=%0b busy=%0b, need 0 1", bus.wr_trig, bus.busy);
      end
      step(1);
      checks++;
      if (bus.wr_trig !== 1'b1 || bus.busy !== 1'b0 || bus.wfifo_wr_en !== 1'b0) begin
         errors++; $display("FAIL wr_trig: wr_trig=%0b busy=%0b wr_en=%0b, need 1 0 0", bus.wr_trig, bus.busy, bus.wfifo_wr_en);
      end
      step(1);
      checks++;
      if (bus.wr_trig !== 1'b0) begin
         errors++; $display("FAIL wr_trig_width: wr_trig=%0b, need 0", bus.wr_trig);
      end
      @(negedge clk);
      checks++;
      if (n_err - e0 !== 0) begin
         errors++; $display("FAIL wr_no_err: frame_err pulses %0d, need 0", n_err - e0);
      end
   endtask

   task automatic test_read();
      int w0;
      w0 = n_wr;
      bus.sdram_busy = 1'b0;
      strobe(8'hAA);
      checks++;
      if (bus.rd_trig !== 1'b1 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++; $display("FAIL rd_trig: rd=%0b busy=%0b err=%0b, need 1 0 0", bus.rd_trig, bus.busy, bus.frame_err);
      end
      step(1);
      checks++;
      if (bus.rd_trig !== 1'b0) begin
         errors++; $display("FAIL rd_trig_width: rd=%0b, need 0", bus.rd_trig);
      end
      bus.sdram_busy = 1'b1;
      strobe(8'hAA);
      checks++;
      if (bus.rd_trig !== 1'b0 || bus.frame_err !== 1'b1) begin
         errors++; $display("FAIL rd_drop: rd=%0b err=%0b, need 0 1", bus.rd_trig, bus.frame_err);
      end
      step(1);
      strobe(8'h55);
      checks++;
      if (bus.busy !== 1'b0 || bus.frame_err !== 1'b1) begin
         errors++; $display("FAIL wr_drop: busy=%0b err=%0b, need 0 1", bus.busy, bus.frame_err);
      end
      step(1);
      checks++;
      if (bus.frame_err !== 1'b0) begin
         errors++; $display("FAIL drop_width: err=%0b, need 0", bus.frame_err);
      end
      bus.sdram_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (n_wr - w0 !== 0) begin
         errors++; $display("FAIL rd_no_wfifo: wr_en pulses %0d, need 0", n_wr - w0);
      end
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      strobe(8'h55);
      step(3);
      strobe(8'h11);
      step(3);
      strobe(8'h22);
      for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
         step(1);
         if (bus.wfifo_clr !== 1'b0 || bus.frame_err !== 1'b0) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++; $display("FAIL to_early: abort seen in %0d cycles before terminal, need 0", early);
      end
      step(1);
      checks++;
      if (bus.wfifo_clr !== 1'b1 || bus.frame_err !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL to_abort: clr=%0b err=%0b busy=%0b, need 1 1 0", bus.wfifo_clr, bus.frame_err, bus.busy);
      end
      step(1);
      checks++;
      if (bus.wfifo_clr !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++; $display("FAIL to_width: clr=%0b err=%0b, need 0 0", bus.wfifo_clr, bus.frame_err);
      end
      strobe(8'hAA);
      checks++;
      if (bus.rd_trig !== 1'b1) begin
         errors++; $display("FAIL to_then_rd: rd=%0b, need 1", bus.rd_trig);
      end
      step(1);
   endtask

   task automatic test_ignored_and_data_codes();
      logic [7:0] junk [3] = '{8'h00, 8'h7F, 8'h44};
      logic [7:0] pay  [4] = '{8'hAA, 8'h55, 8'hAA, 8'h01};
      int r0;
      for (int i = 0; i < 3; i++) begin
         strobe(junk[i]);
         checks++;
         if (flags() !== 6'b0) begin
            errors++; $display("FAIL ignore_%02h: flags=%b, need 000000", junk[i], flags());
         end
         step(1);
      end
      r0 = n_rt;
      strobe(8'h55);
      for (int i = 0; i < 4; i++) begin
         step(1);
         strobe(pay[i]);
         checks++;
         if (bus.wfifo_wr_en !== 1'b1 || bus.wfifo_data !== pay[i] || bus.rd_trig !== 1'b0) begin
            errors++; $display("FAIL code_data%0d: wr_en=%0b data=%02h rd=%0b, need 1 %02h 0",
                               i, bus.wfifo_wr_en, bus.wfifo_data, bus.rd_trig, pay[i]);
         end
      end
      step(1);
      checks++;
      if (bus.wr_trig !== 1'b1) begin
         errors++; $display("FAIL code_wr_trig: wr_trig=%0b, need 1", bus.wr_trig);
      end
      step(1);
      @(negedge clk);
      checks++;
      if (n_rt - r0 !== 0) begin
         errors++; $display("FAIL code_no_rd: rd_trig pulses %0d, need 0", n_rt - r0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pay [3] = '{8'h22, 8'h33, 8'h44};
      logic [7:0] nxt [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      strobe(8'h55);
      step(TIMEOUT_CYC - 1);
      strobe(8'h11);
      checks++;
      if (bus.wfifo_wr_en !== 1'b1 || bus.wfifo_data !== 8'h11 || bus.wfifo_clr !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++; $display("FAIL terminal_byte: wr_en=%0b data=%02h clr=%0b err=%0b, need 1 11 0 0",
                            bus.wfifo_wr_en, bus.wfifo_data, bus.wfifo_clr, bus.frame_err);
      end
      for (int i = 0; i < 3; i++) begin
         step(1);
         strobe(pay[i]);
      end
      strobe(8'h55);
      checks++;
      if (bus.wr_trig !== 1'b1 || bus.busy !== 1'b1 || bus.wfifo_wr_en !== 1'b0) begin
         errors++; $display("FAIL b2b_start: wr_trig=%0b busy=%0b wr_en=%0b, need 1 1 0", bus.wr_trig, bus.busy, bus.wfifo_wr_en);
      end
      for (int i = 0; i < 4; i++) begin
         step(1);
         strobe(nxt[i]);
         checks++;
         if (bus.wfifo_wr_en !== 1'b1 || bus.wfifo_data !== nxt[i]) begin
            errors++; $display("FAIL b2b_data%0d: wr_en=%0b data=%02h, need 1 %02h", i, bus.wfifo_wr_en, bus.wfifo_data, nxt[i]);
         end
      end
      step(1);
      checks++;
      if (bus.wr_trig !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL b2b_wr_trig: wr_trig=%0b busy=%0b, need 1 0", bus.wr_trig, bus.busy);
      end
      step(1);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] pay [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      int c0;
      strobe(8'h55);
      step(1);
      strobe(8'h11);
      c0 = n_clr;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (flags() !== 6'b0 || bus.wfifo_data !== 8'h00) begin
         errors++; $display("FAIL mid_reset: flags=%b data=%02h, need 000000 00", flags(), bus.wfifo_data);
      end
      step(1);
      strobe(8'h55);
      for (int i = 0; i < 4; i++) begin
         step(1);
         strobe(pay[i]);
         checks++;
         if (bus.wfifo_wr_en !== 1'b1 || bus.wfifo_data !== pay[i]) begin
            errors++; $display("FAIL post_rst_data%0d: wr_en=%0b data=%02h, need 1 %02h", i, bus.wfifo_wr_en, bus.wfifo_data, pay[i]);
         end
      end
      step(1);
      checks++;
      if (bus.wr_trig !== 1'b1) begin
         errors++; $display("FAIL post_rst_wr_trig: wr_trig=%0b, need 1", bus.wr_trig);
      end
      step(2);
      @(negedge clk);
      checks++;
      if (n_clr - c0 !== 0) begin
         errors++; $display("FAIL mid_reset_no_clr: wfifo_clr pulses %0d, need 0", n_clr - c0);
      end
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_read();
      test_timeout();
      test_ignored_and_data_codes();
      test_back_to_back();
      test_reset_midframe();
      checks++;
      if (n_double !== 0) begin
         errors++; $display("FAIL pulse_width: multi-cycle pulses %0d, need 0", n_double);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
